fork_join_ctrl: RTL and testbench

Hardware fork/join sequencer: accepts a launch request, fires a single-cycle start pulse to NUM_BR parallel branch engines, and collects their done pulses. It reports completion with fork-join (all), join_any (first) or join_none (immediate) semantics, and drains or kills the remaining branches afterwards. It sits directly upstream of the branch engines, which it launches, and consumes their completion events.

---
 rtl/fork_join_if.sv | 32 +++
 rtl/fork_join_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_fork_join_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fork_join_if.sv
// Handshake and branch-engine signal bundle for the fork/join sequencer.
// The slave modport is the sequencer; the master modport is the launcher plus branch engines.
interface fork_join_if #(
  parameter int NUM_BR = 2,
  parameter int TO_W   = 8
);
  localparam int FW = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;

  logic              go_valid;
  logic              go_ready;
  logic [1:0]        go_mode;
  logic [TO_W-1:0]   go_timeout;
  logic [NUM_BR-1:0] br_start;
  logic [NUM_BR-1:0] br_done;
  logic [NUM_BR-1:0] br_kill;
  logic              join_valid;
  logic              join_ready;
  logic [FW-1:0]     join_first;
  logic [NUM_BR-1:0] join_mask;
  logic              join_timeout;
  logic              busy;

  modport slave (
    input  go_valid, go_mode, go_timeout, br_done, join_ready,
    output go_ready, br_start, br_kill, join_valid, join_first, join_mask, join_timeout, busy
  );

  modport master (
    output go_valid, go_mode, go_timeout, br_done, join_ready,
    input  go_ready, br_start, br_kill, join_valid, join_first, join_mask, join_timeout, busy
  );
endinterface

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: one start pulse to NUM_BR branch engines, then a join report
// with ALL / ANY / NONE semantics, optional timeout kill, and drain of the stragglers.
module fork_join_ctrl #(
  parameter int NUM_BR = 2,
  parameter int TO_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  fork_join_if.slave fj
);
  localparam int FW = (NUM_BR > 1) ? $clog2(NUM_BR) : 1;
  localparam logic [1:0] MODE_ALL  = 2'd0;
  localparam logic [1:0] MODE_ANY  = 2'd1;
  localparam logic [1:0] MODE_NONE = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPORT, ST_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [TO_W-1:0]   limit_q, limit_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [NUM_BR-1:0] done_q, done_d;
  logic              first_seen_q, first_seen_d;
  logic [FW-1:0]     first_idx_q, first_idx_d;
  logic              go_ready_q, go_ready_d;
  logic              busy_q, busy_d;
  logic [NUM_BR-1:0] br_start_q, br_start_d;
  logic              join_valid_q, join_valid_d;
  logic              join_timeout_q, join_timeout_d;
  logic [FW-1:0]     join_first_q, join_first_d;
  logic [NUM_BR-1:0] join_mask_q, join_mask_d;

  logic [NUM_BR-1:0] done_in;
  logic [NUM_BR-1:0] acc;
  logic [NUM_BR-1:0] lowest_hot;
  logic [NUM_BR-1:0] kill_c;
  logic [FW-1:0]     lowest_idx;
  logic              all_done;
  logic              join_cond;
  logic              limit_hit;
  logic              kill_fire;

  // Done pulses only count once a run is in flight; stale ones in IDLE are dropped.
  assign done_in   = (state_q == ST_IDLE) ? '0 : fj.br_done;
  assign acc       = done_q | done_in;
  assign all_done  = &acc;
  assign limit_hit = (limit_q != '0) && (cnt_q == limit_q);
  assign kill_fire = (state_q == ST_RUN) && limit_hit && !join_cond;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BR; gi++) begin : g_br
      if (gi == 0) begin : g_lo0
        assign lowest_hot[gi] = done_in[gi];
      end else begin : g_lo
        assign lowest_hot[gi] = done_in[gi] & ~(|done_in[gi-1:0]);
      end
      assign kill_c[gi] = kill_fire & ~acc[gi];
    end
  endgenerate

  always_comb begin
    lowest_idx = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (lowest_hot[i]) begin
        lowest_idx = lowest_idx | FW'(i);
      end
    end
  end

  always_comb begin
    case (mode_q)
      MODE_ANY:  join_cond = |acc;
      MODE_NONE: join_cond = 1'b1;
      default:   join_cond = all_done;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    limit_d        = limit_q;
    cnt_d          = cnt_q;
    done_d         = done_q;
    first_seen_d   = first_seen_q;
    first_idx_d    = first_idx_q;
    br_start_d     = '0;
    join_valid_d   = join_valid_q;
    join_timeout_d = join_timeout_q;
    join_first_d   = join_first_q;
    join_mask_d    = join_mask_q;

    case (state_q)
      ST_IDLE: begin
        if (fj.go_valid && go_ready_q) begin
          state_d      = ST_RUN;
          mode_d       = (fj.go_mode == 2'd3) ? MODE_ALL : fj.go_mode;
          limit_d      = fj.go_timeout;
          cnt_d        = TO_W'(1);
          done_d       = '0;
          first_seen_d = 1'b0;
          first_idx_d  = '0;
          br_start_d   = '1;
        end
      end

      ST_RUN: begin
        done_d = acc;
        cnt_d  = cnt_q + TO_W'(1);
        if (!first_seen_q && (|done_in)) begin
          first_seen_d = 1'b1;
          first_idx_d  = lowest_idx;
        end
        // The join condition takes priority over a timeout landing in the same cycle.
        if (join_cond) begin
          state_d        = ST_REPORT;
          join_valid_d   = 1'b1;
          join_timeout_d = 1'b0;
          join_first_d   = first_seen_q ? first_idx_q : lowest_idx;
          join_mask_d    = acc;
        end else if (limit_hit) begin
          state_d        = ST_REPORT;
          join_valid_d   = 1'b1;
          join_timeout_d = 1'b1;
          join_first_d   = '0;
          join_mask_d    = acc;
        end
      end

      ST_REPORT: begin
        done_d = acc;
        if (fj.join_ready) begin
          join_valid_d   = 1'b0;
          join_timeout_d = 1'b0;
          join_first_d   = '0;
          join_mask_d    = '0;
          state_d        = (join_timeout_q || all_done) ? ST_IDLE : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        done_d = acc;
        if (all_done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    go_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      mode_q         <= MODE_ALL;
      limit_q        <= '0;
      cnt_q          <= '0;
      done_q         <= '0;
      first_seen_q   <= 1'b0;
      first_idx_q    <= '0;
      go_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      br_start_q     <= '0;
      join_valid_q   <= 1'b0;
      join_timeout_q <= 1'b0;
      join_first_q   <= '0;
      join_mask_q    <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      limit_q        <= limit_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      first_seen_q   <= first_seen_d;
      first_idx_q    <= first_idx_d;
      go_ready_q     <= go_ready_d;
      busy_q         <= busy_d;
      br_start_q     <= br_start_d;
      join_valid_q   <= join_valid_d;
      join_timeout_q <= join_timeout_d;
      join_first_q   <= join_first_d;
      join_mask_q    <= join_mask_d;
    end
  end

  assign fj.go_ready     = go_ready_q;
  assign fj.busy         = busy_q;
  assign fj.br_start     = br_start_q;
  assign fj.br_kill      = kill_c;
  assign fj.join_valid   = join_valid_q;
  assign fj.join_timeout = join_timeout_q;
  assign fj.join_first   = join_first_q;
  assign fj.join_mask    = join_mask_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Randomized bench for fork_join_ctrl: each launch is predicted from per-branch done
// times (cycle numbers relative to the first RUN cycle) and checked cycle by cycle.
module tb_fork_join_ctrl;
  localparam int NUM_BR = 4;
  localparam int TO_W   = 8;
  localparam int NTXN   = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  int dtime [NUM_BR];
  int dupt  [NUM_BR];

  always #5 clk = ~clk;

  fork_join_if #(.NUM_BR(NUM_BR), .TO_W(TO_W)) fj ();

  fork_join_ctrl #(.NUM_BR(NUM_BR), .TO_W(TO_W)) dut (
    .clk (clk),
    .rst (rst),
    .fj  (fj.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".go_ready"},     32'(fj.go_ready),     32'd0);
    chk({tag, ".busy"},         32'(fj.busy),         32'd0);
    chk({tag, ".br_start"},     32'(fj.br_start),     32'd0);
    chk({tag, ".br_kill"},      32'(fj.br_kill),      32'd0);
    chk({tag, ".join_valid"},   32'(fj.join_valid),   32'd0);
    chk({tag, ".join_first"},   32'(fj.join_first),   32'd0);
    chk({tag, ".join_mask"},    32'(fj.join_mask),    32'd0);
    chk({tag, ".join_timeout"}, 32'(fj.join_timeout), 32'd0);
  endtask

  // Cycle in which the join rule is first satisfied, ignoring any timeout.
  function automatic int join_cycle(input int mode);
    int mind, maxd;
    mind = 1 << 20;
    maxd = 0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (dtime[i] < mind) mind = dtime[i];
      if (dtime[i] > maxd) maxd = dtime[i];
    end
    if (mode == 1) return mind;
    if (mode == 2) return 1;
    return maxd;
  endfunction

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fj.go_valid   = 1'b0;
      fj.br_done    = NUM_BR'($urandom);
      fj.join_ready = 1'($urandom);
      #1;
      chk("idle.go_ready",   32'(fj.go_ready),   32'd1);
      chk("idle.busy",       32'(fj.busy),       32'd0);
      chk("idle.join_valid", 32'(fj.join_valid), 32'd0);
    end
    @(negedge clk);
    fj.br_done = '0;
  endtask

  task automatic run_txn(input int id, input int mode, input int tmo, input int rdly, input bit dup);
    int emode, mind, maxd, jc, jeff, r_cyc, e_cyc, efirst;
    bit to_hit, exp_valid;
    logic [NUM_BR-1:0] emask, ekill, bd, all1;
    all1  = '1;
    emode = (mode == 3) ? 0 : mode;
    mind  = 1 << 20;
    maxd  = 0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (dtime[i] < mind) mind = dtime[i];
      if (dtime[i] > maxd) maxd = dtime[i];
      dupt[i] = dup ? dtime[i] + int'($urandom_range(1, 3)) : -1;
    end
    jc     = join_cycle(emode);
    to_hit = (tmo != 0) && (tmo < jc);
    jeff   = to_hit ? tmo : jc;
    emask  = '0;
    ekill  = '0;
    for (int i = 0; i < NUM_BR; i++) begin
      if (dtime[i] <= jeff) emask[i] = 1'b1;
      else                  ekill[i] = 1'b1;
    end
    efirst = 0;
    if (!to_hit) begin
      for (int i = NUM_BR - 1; i >= 0; i--) begin
        if (dtime[i] == mind && dtime[i] <= jeff) efirst = i;
      end
    end
    r_cyc = jeff + 1 + rdly;
    e_cyc = to_hit ? r_cyc + 1 : ((maxd > r_cyc) ? maxd : r_cyc) + 1;

    // Accept cycle; a stale done here must be ignored.
    @(negedge clk);
    fj.go_valid   = 1'b1;
    fj.go_mode    = 2'(mode);
    fj.go_timeout = TO_W'(tmo);
    fj.br_done    = NUM_BR'($urandom);
    fj.join_ready = 1'($urandom);
    #1;
    chk("accept.go_ready", 32'(fj.go_ready), 32'd1);
    chk("accept.busy",     32'(fj.busy),     32'd0);

    for (int k = 1; k <= e_cyc; k++) begin
      @(negedge clk);
      fj.go_valid = (k < e_cyc) ? 1'($urandom) : 1'b0;
      bd = '0;
      for (int i = 0; i < NUM_BR; i++) begin
        if ((dtime[i] == k || dupt[i] == k) && !(to_hit && dtime[i] > tmo)) bd[i] = 1'b1;
      end
      fj.br_done = bd;
      if (k < jeff + 1 || k > r_cyc) fj.join_ready = 1'($urandom);
      else                           fj.join_ready = (k == r_cyc);
      #1;
      exp_valid = (k >= jeff + 1) && (k <= r_cyc);
      chk("br_start",   32'(fj.br_start),   (k == 1) ? 32'(all1) : 32'd0);
      chk("br_kill",    32'(fj.br_kill),    (to_hit && k == tmo) ? 32'(ekill) : 32'd0);
      chk("join_valid", 32'(fj.join_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("join_first",   32'(fj.join_first),   32'(efirst));
        chk("join_mask",    32'(fj.join_mask),    32'(emask));
        chk("join_timeout", 32'(fj.join_timeout), 32'(to_hit));
      end
      chk("busy",     32'(fj.busy),     32'(k < e_cyc));
      chk("go_ready", 32'(fj.go_ready), 32'(k >= e_cyc));
    end
    fj.br_done = '0;
    $display("txn %0d mode=%0d tmo=%0d d=%0d,%0d,%0d,%0d first=%0d mask=%b timeout=%0d report=%0d idle=%0d",
             id, mode, tmo, dtime[0], dtime[1], dtime[2], dtime[3],
             efirst, emask, to_hit, jeff + 1, e_cyc);
  endtask

  task automatic set_d(input int d0, input int d1, input int d2, input int d3);
    dtime[0] = d0;
    dtime[1] = d1;
    dtime[2] = d2;
    dtime[3] = d3;
  endtask

  initial begin
    int mode, tmo, jc, sel;
    fj.go_valid   = 1'b0;
    fj.go_mode    = 2'd0;
    fj.go_timeout = '0;
    fj.br_done    = '0;
    fj.join_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset.go_ready", 32'(fj.go_ready), 32'd1);
    chk("post_reset.busy",     32'(fj.busy),     32'd0);

    // Directed launches: ALL, ANY with drain, NONE, ANY tie, timeout, timeout==join, mode 3.
    set_d(7, 3, 7, 3);   run_txn(1, 0, 0, 0, 1'b0);
    set_d(5, 10, 10, 10); run_txn(2, 1, 0, 1, 1'b0);
    set_d(4, 6, 3, 8);   run_txn(3, 2, 0, 0, 1'b0);
    set_d(4, 4, 4, 4);   run_txn(4, 1, 0, 2, 1'b0);
    set_d(2, 20, 20, 20); run_txn(5, 0, 6, 1, 1'b0);
    set_d(3, 5, 8, 8);   run_txn(6, 0, 8, 0, 1'b1);
    set_d(2, 2, 9, 1);   run_txn(7, 3, 0, 0, 1'b0);
    set_d(3, 1, 1, 5);   run_txn(8, 2, 1, 0, 1'b0);
    idle_cycles(2);

    // Reset in the middle of a run with join_ready low.
    @(negedge clk);
    fj.go_valid   = 1'b1;
    fj.go_mode    = 2'd0;
    fj.go_timeout = '0;
    fj.join_ready = 1'b0;
    #1;
    chk("rst_run.accept", 32'(fj.go_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      fj.go_valid = 1'b0;
    end
    #1;
    chk("rst_run.busy_before", 32'(fj.busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_run");
    @(negedge clk);
    #1;
    chk_all_zero("rst_run_hold");
    rst = 1'b0;
    fj.br_done = '1;
    @(negedge clk);
    #1;
    chk("rst_release.go_ready",   32'(fj.go_ready),   32'd1);
    chk("rst_release.busy",       32'(fj.busy),       32'd0);
    chk("rst_release.join_valid", 32'(fj.join_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("stale_done.busy", 32'(fj.busy), 32'd0);
    fj.br_done = '0;

    for (int n = 0; n < NTXN; n++) begin
      mode = int'($urandom_range(0, 3));
      for (int i = 0; i < NUM_BR; i++) dtime[i] = int'($urandom_range(1, 12));
      if ($urandom_range(0, 4) == 0) begin
        for (int i = 1; i < NUM_BR; i++) dtime[i] = dtime[0];
      end
      jc  = join_cycle((mode == 3) ? 0 : mode);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       tmo = 0;
        1:       tmo = int'($urandom_range(1, 14));
        2:       tmo = jc;
        default: tmo = (jc > 1) ? jc - 1 : 0;
      endcase
      run_txn(100 + n, mode, tmo, int'($urandom_range(0, 4)), 1'($urandom));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
